// File: rtl/csr_machine_wr.sv
// Machine-mode CSR write/trap unit for the EXE stage: CSRRW/S/C on the machine CSRs,
// interrupt trap entry, mret return, wfi sleep, and a registered PC redirect to IF.
module csr_machine_wr #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [2:0]      funct3,
  input  logic [31:0]     Imm_CSR,
  input  logic [XLEN-1:0] EXE_rs1_data,
  input  logic [4:0]      zimm,
  input  logic [XLEN-1:0] EXE_pc,
  input  logic            mret,
  input  logic            wfi,
  input  logic            Hazardstall_flag,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wfi_sleep
);

  // state | meaning
  // RUN   | normal execution; CSR ops, mret, wfi commit when not stalled
  // SLEEP | parked after wfi; waits for any enabled pending interrupt
  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  state_t            state;
  logic              mstatus_mie;
  logic              mstatus_mpie;
  logic              mie_mtie;
  logic              mie_meie;
  logic [XLEN-1:2]   mtvec;
  logic [XLEN-1:2]   mepc;
  logic [XLEN-1:0]   mcause;
  logic [XLEN-1:0]   mscratch;
  logic [XLEN-1:2]   wfi_pc;

  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   mie_val;
  logic [XLEN-1:0]   mip_val;
  logic [XLEN-1:0]   src;
  logic [XLEN-1:0]   new_val;
  logic              op_valid;
  logic              pend_ext;
  logic              pend_tmr;
  logic              pend_any;
  logic              commit;
  logic              take;
  logic              csr_wr;
  logic [XLEN-1:2]   wfi_resume;

  logic              unused_ok;
  assign unused_ok = ^{Imm_CSR[31:12], EXE_pc[1:0]};

  assign csr_addr = Imm_CSR[11:0];

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mstatus_mpie;
    mstatus_val[3]     = mstatus_mie;

    mie_val            = '0;
    mie_val[7]         = mie_mtie;
    mie_val[11]        = mie_meie;

    mip_val            = '0;
    mip_val[7]         = tmr_irq;
    mip_val[11]        = ext_irq;
  end

  always_comb begin
    csr_rd_data = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rd_data = mstatus_val;
      ADDR_MIE:      csr_rd_data = mie_val;
      ADDR_MTVEC:    csr_rd_data = {mtvec, 2'b00};
      ADDR_MSCRATCH: csr_rd_data = mscratch;
      ADDR_MEPC:     csr_rd_data = {mepc, 2'b00};
      ADDR_MCAUSE:   csr_rd_data = mcause;
      ADDR_MIP:      csr_rd_data = mip_val;
      default:       csr_rd_data = '0;
    endcase
  end

  // funct3[2] selects the zero-extended immediate; [1:0] picks RW/RS/RC.
  always_comb begin
    src      = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : EXE_rs1_data;
    op_valid = (funct3[1:0] != 2'b00);
    case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = csr_rd_data | src;
      2'b11:   new_val = csr_rd_data & ~src;
      default: new_val = csr_rd_data;
    endcase
  end

  assign pend_ext   = ext_irq & mie_meie;
  assign pend_tmr   = tmr_irq & mie_mtie;
  assign pend_any   = pend_ext | pend_tmr;
  assign commit     = (state == RUN) && !Hazardstall_flag;
  assign take       = mstatus_mie && pend_any && !mret && (commit || (state == SLEEP));
  assign csr_wr     = commit && csr_en && op_valid && !take;
  assign wfi_resume = wfi_pc + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_mtie       <= 1'b0;
      mie_meie       <= 1'b0;
      mtvec          <= RESET_MTVEC[XLEN-1:2];
      mepc           <= '0;
      mcause         <= '0;
      mscratch       <= '0;
      wfi_pc         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wfi_sleep      <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (take) begin
        // Trap entry discards whatever instruction is sitting in EXE.
        mepc           <= (state == SLEEP) ? wfi_resume : EXE_pc[XLEN-1:2];
        mcause         <= pend_ext ? CAUSE_EXT : CAUSE_TMR;
        mstatus_mpie   <= mstatus_mie;
        mstatus_mie    <= 1'b0;
        state          <= RUN;
        wfi_sleep      <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= {mtvec, 2'b00};
      end else if (state == SLEEP) begin
        if (pend_any) begin
          state     <= RUN;
          wfi_sleep <= 1'b0;
        end
      end else if (commit) begin
        if (csr_wr) begin
          case (csr_addr)
            ADDR_MSTATUS: begin
              mstatus_mie  <= new_val[3];
              mstatus_mpie <= new_val[7];
            end
            ADDR_MIE: begin
              mie_mtie <= new_val[7];
              mie_meie <= new_val[11];
            end
            ADDR_MTVEC:    mtvec    <= new_val[XLEN-1:2];
            ADDR_MSCRATCH: mscratch <= new_val;
            ADDR_MEPC:     mepc     <= new_val[XLEN-1:2];
            ADDR_MCAUSE:   mcause   <= new_val;
            default: ;
          endcase
        end
        if (mret) begin
          mstatus_mie    <= mstatus_mpie;
          mstatus_mpie   <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= {mepc, 2'b00};
        end
        if (wfi && !pend_any) begin
          wfi_pc    <= EXE_pc[XLEN-1:2];
          state     <= SLEEP;
          wfi_sleep <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_machine_wr.sv
// Directed and randomized bench for csr_machine_wr against a CSR-level reference model.
module tb_csr_machine_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] Imm_CSR = '0;
  logic [31:0] EXE_rs1_data = '0;
  logic [4:0]  zimm = '0;
  logic [31:0] EXE_pc = '0;
  logic        mret = 1'b0;
  logic        wfi = 1'b0;
  logic        Hazardstall_flag = 1'b0;
  logic        ext_irq = 1'b0;
  logic        tmr_irq = 1'b0;
  logic [31:0] csr_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wfi_sleep;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural CSR contents stored already masked.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch, m_wfi_pc, m_rpc;
  logic        m_sleep, m_rv;

  logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                             12'h341, 12'h342, 12'h344, 12'h123};

  csr_machine_wr #(.XLEN(32), .RESET_MTVEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .funct3(funct3), .Imm_CSR(Imm_CSR),
    .EXE_rs1_data(EXE_rs1_data), .zimm(zimm), .EXE_pc(EXE_pc), .mret(mret), .wfi(wfi),
    .Hazardstall_flag(Hazardstall_flag), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_rd_data(csr_rd_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .wfi_sleep(wfi_sleep)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus | 32'h0000_1800;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (ext_irq ? 32'h800 : 32'h0) | (tmr_irq ? 32'h80 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    m_mscratch = 0; m_wfi_pc = 0; m_rpc = 0; m_sleep = 0; m_rv = 0;
  endtask

  task automatic m_update();
    logic [31:0] pend, old, src, nv;
    logic        commit, take;
    if (rst) begin
      m_reset();
      return;
    end
    pend   = m_read(12'h344) & m_mie;
    commit = !Hazardstall_flag && !m_sleep;
    take   = m_mstatus[3] && (pend != 0) && !mret && (commit || m_sleep);
    m_rv   = 1'b0;
    if (take) begin
      m_mepc    = (m_sleep ? m_wfi_pc + 32'd4 : EXE_pc) & ~32'h3;
      m_mcause  = ((pend & 32'h800) != 0) ? 32'h8000_000B : 32'h8000_0007;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      m_sleep   = 1'b0;
      m_rv      = 1'b1;
      m_rpc     = m_mtvec;
    end else if (m_sleep) begin
      if (pend != 0) m_sleep = 1'b0;
    end else if (commit) begin
      if (csr_en && funct3[1:0] != 2'b00) begin
        old = m_read(Imm_CSR[11:0]);
        src = funct3[2] ? {27'b0, zimm} : EXE_rs1_data;
        nv  = (funct3[1:0] == 2'b01) ? src :
              (funct3[1:0] == 2'b10) ? (old | src) : (old & ~src);
        case (Imm_CSR[11:0])
          12'h300: m_mstatus  = nv & 32'h88;
          12'h304: m_mie      = nv & 32'h880;
          12'h305: m_mtvec    = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          default: ;
        endcase
      end
      if (mret) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        m_rv      = 1'b1;
        m_rpc     = m_mepc;
      end
      if (wfi && pend == 0) begin
        m_wfi_pc = EXE_pc;
        m_sleep  = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek();
    @(negedge clk);
    chk("csr_rd_data", csr_rd_data, m_read(Imm_CSR[11:0]));
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("wfi_sleep", {31'b0, wfi_sleep}, {31'b0, m_sleep});
  endtask

  task automatic adv();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] zi);
    csr_en = 1'b1; funct3 = f3; Imm_CSR = {20'h0, a}; EXE_rs1_data = rs1; zimm = zi;
    peek(); adv();
    csr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    Imm_CSR = {20'h0, a};
    peek(); chk(tag, csr_rd_data, exp); adv();
  endtask

  initial begin
    logic [31:0] r;
    int unsigned op;
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    Imm_CSR = 32'h305;
    peek(); chk("reset_mtvec", csr_rd_data, 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0); adv();

    csr_en = 1'b1; funct3 = 3'b001; Imm_CSR = 32'h305; EXE_rs1_data = 32'h8000_0103;
    peek(); chk("csrrw_old_value", csr_rd_data, 32'h0); adv();
    csr_en = 1'b0;
    rd("mtvec_after_write", 12'h305, 32'h8000_0100);

    csr_op(3'b110, 12'h300, 32'h0, 5'd8);
    rd("mstatus_after_rsi", 12'h300, 32'h0000_1808);
    csr_op(3'b111, 12'h300, 32'h0, 5'd8);
    rd("mstatus_after_rci", 12'h300, 32'h0000_1800);

    // Trap: external beats timer.
    csr_op(3'b110, 12'h300, 32'h0, 5'd8);
    csr_op(3'b001, 12'h304, 32'h0000_0880, 5'd0);
    ext_irq = 1'b1; tmr_irq = 1'b1; EXE_pc = 32'h40;
    peek(); chk("no_redirect_before_trap", {31'b0, redirect_valid}, 32'h0); adv();
    ext_irq = 1'b0; tmr_irq = 1'b0; Imm_CSR = 32'h342;
    peek();
    chk("trap_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("trap_redirect_pc", redirect_pc, 32'h8000_0100);
    chk("trap_mcause", csr_rd_data, 32'h8000_000B);
    adv();
    rd("trap_mepc", 12'h341, 32'h40);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);

    mret = 1'b1; EXE_pc = 32'h44;
    peek(); adv();
    mret = 1'b0; Imm_CSR = 32'h300;
    peek();
    chk("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("mret_redirect_pc", redirect_pc, 32'h40);
    chk("mret_mstatus", csr_rd_data, 32'h0000_1888);
    adv();
    peek(); chk("mret_pulse_one_cycle", {31'b0, redirect_valid}, 32'h0); adv();

    // wfi with MIE=1: timer wakes into a trap with mepc = wfi_pc + 4.
    wfi = 1'b1; EXE_pc = 32'h100;
    peek(); adv();
    wfi = 1'b0;
    peek(); chk("wfi_sleep_set", {31'b0, wfi_sleep}, 32'h1); adv();
    peek(); adv();
    tmr_irq = 1'b1; Imm_CSR = 32'h341;
    peek(); chk("sleep_high_on_exit_cycle", {31'b0, wfi_sleep}, 32'h1); adv();
    tmr_irq = 1'b0;
    peek();
    chk("wake_trap_redirect", {31'b0, redirect_valid}, 32'h1);
    chk("wake_trap_mepc", csr_rd_data, 32'h104);
    chk("wake_sleep_clear", {31'b0, wfi_sleep}, 32'h0);
    adv();

    // wfi with MIE=0: wake without a redirect.
    wfi = 1'b1; EXE_pc = 32'h200;
    peek(); adv();
    wfi = 1'b0;
    peek(); chk("wfi_sleep_set_mie0", {31'b0, wfi_sleep}, 32'h1); adv();
    tmr_irq = 1'b1;
    peek(); adv();
    peek();
    chk("wake_mie0_sleep_clear", {31'b0, wfi_sleep}, 32'h0);
    chk("wake_mie0_no_redirect", {31'b0, redirect_valid}, 32'h0);
    adv();
    tmr_irq = 1'b0;

    // Stall holds a pending enabled interrupt until the first commit cycle.
    csr_op(3'b110, 12'h300, 32'h0, 5'd8);
    tmr_irq = 1'b1; Hazardstall_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      peek(); adv();
    end
    peek(); chk("stall_no_redirect", {31'b0, redirect_valid}, 32'h0);
    Hazardstall_flag = 1'b0; adv();
    tmr_irq = 1'b0;
    peek(); chk("trap_after_stall", {31'b0, redirect_valid}, 32'h1); adv();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 9);
      csr_en = (op < 4);
      mret = (op == 4);
      wfi = (op == 5 || op == 6);
      funct3 = 3'($urandom_range(0, 7));
      Imm_CSR = {r[31:12], addrs[$urandom_range(0, 7)]};
      EXE_rs1_data = $urandom;
      zimm = 5'($urandom_range(0, 31));
      EXE_pc = $urandom;
      Hazardstall_flag = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 7) == 0) tmr_irq = ~tmr_irq;
      peek(); adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
